// File: rtl/fetch_seq_pkg.sv
// Shared types and widths for the instruction fetch sequencer.
// States: IDLE -> IFETCH -> EXEC -> {DATA | IFETCH | HALTED}.
package fetch_seq_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_IFETCH = 3'd1,
        S_EXEC   = 3'd2,
        S_DATA   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

endpackage

// File: rtl/fetch_timeout.sv
// Bus-wait cycle counter: counts cycles while running, expires on the TIMEOUT_CYC-th.
// Only compiled when FETCH_SEQ_TIMEOUT_EN is defined.
`ifdef FETCH_SEQ_TIMEOUT_EN
module fetch_timeout #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_clear,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_start && !o_expired) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Fires during the last permitted wait cycle so the request drops on the next edge.
    assign o_expired = i_start && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule
`endif

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: owns the PC, drives the req/ack memory port, runs data cycles.
// Optional bus-timeout fault enabled with FETCH_SEQ_TIMEOUT_EN.
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC    = 16'h0000,
    parameter int                TIMEOUT_CYC = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ack,
    output logic [DATA_W-1:0] o_instr,
    output logic              o_instr_valid,
    input  logic              i_exec_fetch,
    input  logic              i_exec_we,
    input  logic [ADDR_W-1:0] i_data_addr,
    input  logic [DATA_W-1:0] i_data_wdata,
    output logic [DATA_W-1:0] o_data_rdata,
    output logic              o_data_valid,
    input  logic              i_pc_load,
    input  logic [ADDR_W-1:0] i_pc_load_val,
    input  logic              i_halt,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_fault,
    output state_t            o_dbg_state
);

    // Memory port: o_mem_req rises one cycle after entering IFETCH/DATA and stays high
    // with addr/we/wdata frozen until i_mem_ack is sampled high; ack is ignored while req=0.

    state_t            r_state;
    state_t            w_state_next;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] r_data_rdata;
    logic              r_data_valid;
    logic [ADDR_W-1:0] r_pc;
    logic              w_expired;
    logic              w_fault;
    logic              w_xfer_done;

    assign w_xfer_done = r_mem_req && i_mem_ack;

`ifdef FETCH_SEQ_TIMEOUT_EN
    logic w_tmo_run;
    logic w_tmo_clear;
    logic r_fault;

    assign w_tmo_run   = r_mem_req && !i_mem_ack;
    assign w_tmo_clear = !w_tmo_run;

    fetch_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (w_tmo_run),
        .i_clear  (w_tmo_clear),
        .o_expired(w_expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fault <= 1'b0;
        end else if (w_expired) begin
            r_fault <= 1'b1;
        end
    end

    assign w_fault = r_fault;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYC != 0);
    assign w_expired        = 1'b0;
    assign w_fault          = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   w_state_next = S_IFETCH;
            S_IFETCH: begin
                if (w_expired)        w_state_next = S_HALTED;
                else if (w_xfer_done) w_state_next = S_EXEC;
            end
            S_EXEC: begin
                if (i_exec_fetch)     w_state_next = S_DATA;
                else if (i_halt)      w_state_next = S_HALTED;
                else                  w_state_next = S_IFETCH;
            end
            S_DATA: begin
                if (w_expired)        w_state_next = S_HALTED;
                else if (w_xfer_done) w_state_next = i_halt ? S_HALTED : S_IFETCH;
            end
            S_HALTED: begin
                // A bus fault pins the sequencer here until reset.
                if (!i_halt && !w_fault) w_state_next = S_IFETCH;
            end
            default:                  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_instr      <= '0;
            r_data_rdata <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_data_valid <= 1'b0;
            case (r_state)
                S_IFETCH: begin
                    if (!r_mem_req) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= r_pc;
                    end else if (i_mem_ack) begin
                        r_instr   <= i_mem_rdata;
                        r_pc      <= r_pc + ADDR_W'(1);
                        r_mem_req <= 1'b0;
                    end else if (w_expired) begin
                        r_mem_req <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (i_pc_load) begin
                        r_pc <= i_pc_load_val;
                    end
                    if (i_exec_fetch) begin
                        r_mem_addr  <= i_data_addr;
                        r_mem_we    <= i_exec_we;
                        r_mem_wdata <= i_data_wdata;
                    end
                end
                S_DATA: begin
                    if (!r_mem_req) begin
                        r_mem_req <= 1'b1;
                    end else if (i_mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (!r_mem_we) begin
                            r_data_rdata <= i_mem_rdata;
                            r_data_valid <= 1'b1;
                        end
                    end else if (w_expired) begin
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_mem_req     = r_mem_req;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_instr       = r_instr;
    assign o_instr_valid = (r_state == S_EXEC);
    assign o_data_rdata  = r_data_rdata;
    assign o_data_valid  = r_data_valid;
    assign o_pc          = r_pc;
    assign o_fault       = w_fault;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_seq.sv
// Testbench for fetch_seq: directed vector table, hand-written reset/halt/timeout
// sequences, then randomized instructions checked against a program-level PC model.
module tb_fetch_seq;
    import fetch_seq_pkg::*;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int          TMO      = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [7:0]  instr;
    logic        instr_valid;
    logic        exec_fetch, exec_we;
    logic [15:0] data_addr;
    logic [7:0]  data_wdata;
    logic [7:0]  data_rdata;
    logic        data_valid;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic        halt;
    logic [15:0] pc;
    logic        fault;
    state_t      dbg_state;

    fetch_seq #(
        .RESET_PC   (RESET_PC),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_mem_req    (mem_req),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .i_mem_ack    (mem_ack),
        .o_instr      (instr),
        .o_instr_valid(instr_valid),
        .i_exec_fetch (exec_fetch),
        .i_exec_we    (exec_we),
        .i_data_addr  (data_addr),
        .i_data_wdata (data_wdata),
        .o_data_rdata (data_rdata),
        .o_data_valid (data_valid),
        .i_pc_load    (pc_load),
        .i_pc_load_val(pc_load_val),
        .i_halt       (halt),
        .o_pc         (pc),
        .o_fault      (fault),
        .o_dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  last_rd   = 8'h00;
    int          last_exec = 0;
    bit          prev_plain = 1'b0;
    logic [15:0] pc_m;

    typedef struct {
        int unsigned iwait;
        logic [7:0]  ins;
        logic        xf;
        logic        xwe;
        logic [15:0] daddr;
        logic [7:0]  dwdata;
        int unsigned dwait;
        logic [7:0]  drdata;
        logic        pl;
        logic [15:0] plv;
        logic        hlt;
        logic [15:0] exp_faddr;
        logic [15:0] exp_pc_exec;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(int unsigned iw, logic [7:0] ins, logic xf, logic xwe,
                                logic [15:0] da, logic [7:0] dwd, int unsigned dw,
                                logic [7:0] drd, logic pl, logic [15:0] plv, logic hlt,
                                logic [15:0] fa, logic [15:0] pce);
        vec_t v;
        v.iwait = iw;  v.ins = ins;  v.xf = xf;  v.xwe = xwe;  v.daddr = da;
        v.dwdata = dwd;  v.dwait = dw;  v.drdata = drd;  v.pl = pl;  v.plv = plv;
        v.hlt = hlt;  v.exp_faddr = fa;  v.exp_pc_exec = pce;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (mem_req) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic fetch_exec(input vec_t r);
        bit          ok;
        logic [15:0] fa;
        fa = exp_q.pop_front();
        wait_req(ok);
        chk("fetch_req_seen", 32'(ok), 32'd1);
        if (!ok) return;
        chk("fetch_addr", 32'(mem_addr), 32'(fa));
        chk("fetch_we", 32'(mem_we), 32'd0);
        for (int k = 0; k < int'(r.iwait); k++) begin
            @(negedge clk);
            chk("fetch_req_hold", 32'(mem_req), 32'd1);
            chk("fetch_addr_hold", 32'(mem_addr), 32'(fa));
            chk("no_early_valid", 32'(instr_valid), 32'd0);
        end
        mem_ack   = 1'b1;
        mem_rdata = r.ins;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        chk("instr_valid", 32'(instr_valid), 32'd1);
        chk("instr", 32'(instr), 32'(r.ins));
        chk("pc_in_exec", 32'(pc), 32'(r.exp_pc_exec));
        chk("req_low_exec", 32'(mem_req), 32'd0);
        if (prev_plain && r.iwait == 0)
            chk("cyc_per_instr", 32'(cyc - last_exec), 32'd3);
        last_exec   = cyc;
        exec_fetch  = r.xf;
        exec_we     = r.xwe;
        data_addr   = r.daddr;
        data_wdata  = r.dwdata;
        pc_load     = r.pl;
        pc_load_val = r.plv;
        halt        = r.hlt;
        @(negedge clk);
        exec_fetch  = 1'b0;
        exec_we     = 1'b0;
        pc_load     = 1'b0;
        data_addr   = 16'($urandom);
        data_wdata  = 8'($urandom);
        pc_load_val = 16'($urandom);
        chk("instr_valid_pulse", 32'(instr_valid), 32'd0);
        chk("instr_held", 32'(instr), 32'(r.ins));
    endtask

    task automatic data_cycle(input vec_t r);
        bit ok;
        wait_req(ok);
        chk("data_req_seen", 32'(ok), 32'd1);
        if (!ok) return;
        chk("data_addr", 32'(mem_addr), 32'(r.daddr));
        chk("data_we", 32'(mem_we), 32'(r.xwe));
        if (r.xwe) chk("data_wdata", 32'(mem_wdata), 32'(r.dwdata));
        for (int k = 0; k < int'(r.dwait); k++) begin
            @(negedge clk);
            chk("data_addr_hold", 32'(mem_addr), 32'(r.daddr));
            chk("data_valid_early", 32'(data_valid), 32'd0);
        end
        mem_ack   = 1'b1;
        mem_rdata = r.drdata;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        if (!r.xwe) last_rd = r.drdata;
        chk("data_valid", 32'(data_valid), 32'(!r.xwe));
        chk("data_rdata", 32'(data_rdata), 32'(last_rd));
        @(negedge clk);
        chk("data_valid_pulse", 32'(data_valid), 32'd0);
    endtask

    task automatic halt_hold(input vec_t r);
        logic [15:0] hpc;
        hpc = r.pl ? r.plv : r.exp_pc_exec;
        repeat (4) begin
            @(negedge clk);
            chk("halted_req", 32'(mem_req), 32'd0);
            chk("halted_pc", 32'(pc), 32'(hpc));
        end
        halt = 1'b0;
    endtask

    task automatic run_vec(input vec_t r);
        exp_q.push_back(r.exp_faddr);
        fetch_exec(r);
        if (r.xf) data_cycle(r);
        if (r.hlt) halt_hold(r);
        prev_plain = !r.xf && !r.hlt;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main test ----------------
    initial begin
        vec_t r;
        int   n;
        mem_ack = 1'b0;  mem_rdata = 8'h00;  exec_fetch = 1'b0;  exec_we = 1'b0;
        data_addr = 16'h0;  data_wdata = 8'h0;  pc_load = 1'b0;  pc_load_val = 16'h0;
        halt = 1'b0;  rst = 1'b1;

        tbl[0]  = mk(0, 8'h12, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 16'h0000, 0, 16'h0000, 16'h0001);
        tbl[1]  = mk(3, 8'h34, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 16'h0000, 0, 16'h0001, 16'h0002);
        tbl[2]  = mk(0, 8'h56, 1, 0, 16'h1234, 8'h00, 0, 8'hAB, 0, 16'h0000, 0, 16'h0002, 16'h0003);
        tbl[3]  = mk(1, 8'h78, 1, 1, 16'hBEEF, 8'h5A, 2, 8'h00, 1, 16'hFFFF, 0, 16'h0003, 16'h0004);
        tbl[4]  = mk(0, 8'h9A, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 16'h0040, 0, 16'hFFFF, 16'h0000);
        tbl[5]  = mk(0, 8'hBC, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 16'h0000, 0, 16'h0040, 16'h0041);
        tbl[6]  = mk(2, 8'hDE, 1, 0, 16'h0100, 8'h00, 1, 8'h77, 0, 16'h0000, 1, 16'h0041, 16'h0042);
        tbl[7]  = mk(0, 8'hF0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 16'h0000, 0, 16'h0042, 16'h0043);
        tbl[8]  = mk(0, 8'h11, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 16'h0000, 0, 16'h0043, 16'h0044);
        tbl[9]  = mk(0, 8'h22, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 16'h0000, 1, 16'h0044, 16'h0045);
        tbl[10] = mk(0, 8'h33, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 16'h0000, 0, 16'h0045, 16'h0046);

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_data_rdata", 32'(data_rdata), 32'd0);
        chk("rst_data_valid", 32'(data_valid), 32'd0);
        chk("rst_pc", 32'(pc), 32'(RESET_PC));
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
        rst = 1'b0;

        // Ack while idle must not start anything
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_ack_ignored", 32'(instr_valid), 32'd0);

        for (int i = 0; i < 11; i++) run_vec(tbl[i]);

        // Reset during a pending data read; the late ack must be ignored
        r = mk(0, 8'h5C, 1, 0, 16'h2222, 8'h00, 0, 8'h00, 0, 16'h0000, 0, 16'h0046, 16'h0047);
        exp_q.push_back(r.exp_faddr);
        fetch_exec(r);
        begin
            bit ok;
            wait_req(ok);
            chk("abort_req_seen", 32'(ok), 32'd1);
            chk("abort_addr", 32'(mem_addr), 32'h2222);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_req_drop", 32'(mem_req), 32'd0);
        chk("abort_pc", 32'(pc), 32'(RESET_PC));
        chk("abort_state", 32'(dbg_state), 32'(S_IDLE));
        rst     = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        chk("late_ack_req", 32'(mem_req), 32'd0);
        chk("late_ack_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_data_valid", 32'(data_valid), 32'd0);
        chk("late_ack_rdata", 32'(data_rdata), 32'd0);
        chk("late_ack_pc", 32'(pc), 32'(RESET_PC));
        last_rd    = 8'h00;
        prev_plain = 1'b0;
        pc_m       = RESET_PC;

        // Random instruction stream against the program-level PC model
        for (int i = 0; i < 60; i++) begin
            r.iwait  = $urandom_range(0, 3);
            r.ins    = 8'($urandom);
            r.xf     = ($urandom_range(0, 2) == 0);
            r.xwe    = 1'($urandom);
            r.daddr  = 16'($urandom);
            r.dwdata = 8'($urandom);
            r.dwait  = $urandom_range(0, 2);
            r.drdata = 8'($urandom);
            r.pl     = ($urandom_range(0, 4) == 0);
            r.plv    = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            r.hlt    = ($urandom_range(0, 7) == 0);
            r.exp_faddr   = pc_m;
            r.exp_pc_exec = pc_m + 16'd1;
            pc_m = r.pl ? r.plv : pc_m + 16'd1;
            run_vec(r);
        end

`ifdef FETCH_SEQ_TIMEOUT_EN
        do_reset(2);
        begin
            bit ok;
            wait_req(ok);
            chk("tmo_req_seen", 32'(ok), 32'd1);
        end
        n = 0;
        for (int k = 0; k < 40 && mem_req; k++) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_req_cycles", 32'(n), 32'(TMO));
        chk("tmo_fault", 32'(fault), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("tmo_stuck_req", 32'(mem_req), 32'd0);
            chk("tmo_fault_sticky", 32'(fault), 32'd1);
        end
`else
        n = 0;
        chk("fault_tied_low", 32'(fault), 32'(n));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
